// File: rtl/sdram_mport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_mport_arbiter
// Description : N-channel Avalon-MM arbiter in front of a single-port SDRAM
//               controller slave. Round-robin grant, one command in flight on
//               the slave side. Read data is routed back to the issuing
//               channel through an in-order tag FIFO.
// Ports       : clk_clk / reset_reset_n   - clock, async active-low reset
//               m_*                        - NUM_CH packed upstream masters
//               sdram_* (out)              - registered command to controller
//               sdram_readdata/valid/waitrequest (in) - controller responses
//               err_orphan                 - sticky: read data with no owner
// Options     : ARB_FIXED_PRIO_EN - ch0 wins whenever eligible; the other
//               channels round-robin among themselves.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_mport_arbiter #(
    parameter  int NUM_CH = 4,
    parameter  int ADDR_W = 25,
    parameter  int DATA_W = 16,
    parameter  int MAX_RD = 8,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [NUM_CH*ADDR_W-1:0] m_address,
    input  logic [NUM_CH*BE_W-1:0]   m_byteenable_n,
    input  logic [NUM_CH-1:0]        m_chipselect,
    input  logic [NUM_CH*DATA_W-1:0] m_writedata,
    input  logic [NUM_CH-1:0]        m_read_n,
    input  logic [NUM_CH-1:0]        m_write_n,
    output logic [DATA_W-1:0]        m_readdata,
    output logic [NUM_CH-1:0]        m_readdatavalid,
    output logic [NUM_CH-1:0]        m_waitrequest,
    output logic [ADDR_W-1:0]        sdram_address,
    output logic [BE_W-1:0]          sdram_byteenable_n,
    output logic                     sdram_chipselect,
    output logic [DATA_W-1:0]        sdram_writedata,
    output logic                     sdram_read_n,
    output logic                     sdram_write_n,
    input  logic [DATA_W-1:0]        sdram_readdata,
    input  logic                     sdram_readdatavalid,
    input  logic                     sdram_waitrequest,
    output logic                     err_orphan
);

    localparam int TAG_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
    localparam int CNT_W = $clog2(MAX_RD) + 1;

    localparam logic [CNT_W-1:0] C_MAX_RD   = CNT_W'(MAX_RD);
    localparam logic [TAG_W-1:0] C_LAST_CH  = TAG_W'(NUM_CH - 1);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(MAX_RD - 1);
    localparam logic [TAG_W:0]   C_NUM_CH_X = (TAG_W+1)'(NUM_CH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t             r_state;
    logic [TAG_W-1:0]   r_grant;
    logic [TAG_W-1:0]   r_last_grant;
    logic [ADDR_W-1:0]  r_sdram_address;
    logic [BE_W-1:0]    r_sdram_byteenable_n;
    logic               r_sdram_chipselect;
    logic [DATA_W-1:0]  r_sdram_writedata;
    logic               r_sdram_read_n;
    logic               r_sdram_write_n;

    logic [TAG_W-1:0]   r_tag_mem [MAX_RD];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_err_orphan;

    logic [NUM_CH-1:0]  w_req;
    logic [NUM_CH-1:0]  w_elig;
    logic [NUM_CH-1:0]  w_elig_rr;
    logic               w_found;
    logic [TAG_W-1:0]   w_winner;
    logic [TAG_W:0]     w_idx;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic [TAG_W-1:0]   w_head;

    // Exactly one strobe low makes a request; a read additionally needs a
    // free tag slot (registered count, so a pop this cycle frees nothing).
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_req
        assign w_req[gi]  = m_chipselect[gi] && (!m_read_n[gi] ^ !m_write_n[gi]);
        assign w_elig[gi] = w_req[gi] && (!m_write_n[gi] || (r_count < C_MAX_RD));
    end

    // Round-robin search beginning just after the last accepted channel.
    always_comb begin
        w_elig_rr = w_elig;
`ifdef ARB_FIXED_PRIO_EN
        w_elig_rr[0] = 1'b0;
`endif
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = {1'b0, r_last_grant} + (TAG_W+1)'(k) + (TAG_W+1)'(1);
            if (w_idx >= C_NUM_CH_X) begin
                w_idx = w_idx - C_NUM_CH_X;
            end
            if (!w_found && w_elig_rr[w_idx[TAG_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[TAG_W-1:0];
            end
        end
`ifdef ARB_FIXED_PRIO_EN
        if (w_elig[0]) begin
            w_found  = 1'b1;
            w_winner = '0;
        end
`endif
    end

    assign w_accept = (r_state == S_ISSUE) && !sdram_waitrequest;
    assign w_push   = w_accept && !r_sdram_read_n;
    assign w_pop    = sdram_readdatavalid && (r_count != '0);
    assign w_head   = r_tag_mem[r_rd_ptr];

    // Stall release and read-data qualifier are combinational so the master
    // sees them in the same cycle as the controller event.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan_out
        assign m_waitrequest[gi]   = !(w_accept && (r_grant == TAG_W'(gi)));
        assign m_readdatavalid[gi] = w_pop && (w_head == TAG_W'(gi));
    end

    assign m_readdata         = sdram_readdata;
    assign sdram_address      = r_sdram_address;
    assign sdram_byteenable_n = r_sdram_byteenable_n;
    assign sdram_chipselect   = r_sdram_chipselect;
    assign sdram_writedata    = r_sdram_writedata;
    assign sdram_read_n       = r_sdram_read_n;
    assign sdram_write_n      = r_sdram_write_n;
    assign err_orphan         = r_err_orphan;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state              <= S_IDLE;
            r_grant              <= '0;
            r_last_grant         <= C_LAST_CH;
            r_sdram_address      <= '0;
            r_sdram_byteenable_n <= '0;
            r_sdram_chipselect   <= 1'b0;
            r_sdram_writedata    <= '0;
            r_sdram_read_n       <= 1'b1;
            r_sdram_write_n      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant              <= w_winner;
                        r_sdram_address      <= m_address[w_winner*ADDR_W +: ADDR_W];
                        r_sdram_byteenable_n <= m_byteenable_n[w_winner*BE_W +: BE_W];
                        r_sdram_writedata    <= m_writedata[w_winner*DATA_W +: DATA_W];
                        r_sdram_read_n       <= m_read_n[w_winner];
                        r_sdram_write_n      <= m_write_n[w_winner];
                        r_sdram_chipselect   <= 1'b1;
                        r_state              <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!sdram_waitrequest) begin
                        r_sdram_chipselect <= 1'b0;
                        r_sdram_read_n     <= 1'b1;
                        r_sdram_write_n    <= 1'b1;
`ifdef ARB_FIXED_PRIO_EN
                        // ch0 sits outside the rotation, so it never moves the pointer.
                        if (r_grant != '0) begin
                            r_last_grant <= r_grant;
                        end
`else
                        r_last_grant <= r_grant;
`endif
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // In-order tag FIFO. Pop reads the pre-push head; data arriving with the
    // FIFO empty is dropped and flagged, even if a push happens that cycle.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
            if (sdram_readdatavalid && (r_count == '0)) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= r_grant;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_mport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_mport_arbiter
// Description : Directed self-checking bench for sdram_mport_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_mport_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int MAX_RD = 8;
    localparam int BE_W   = DATA_W / 8;

    logic                     clk_clk = 1'b0;
    logic                     reset_reset_n;
    logic [NUM_CH*ADDR_W-1:0] m_address;
    logic [NUM_CH*BE_W-1:0]   m_byteenable_n;
    logic [NUM_CH-1:0]        m_chipselect;
    logic [NUM_CH*DATA_W-1:0] m_writedata;
    logic [NUM_CH-1:0]        m_read_n;
    logic [NUM_CH-1:0]        m_write_n;
    logic [DATA_W-1:0]        m_readdata;
    logic [NUM_CH-1:0]        m_readdatavalid;
    logic [NUM_CH-1:0]        m_waitrequest;
    logic [ADDR_W-1:0]        sdram_address;
    logic [BE_W-1:0]          sdram_byteenable_n;
    logic                     sdram_chipselect;
    logic [DATA_W-1:0]        sdram_writedata;
    logic                     sdram_read_n;
    logic                     sdram_write_n;
    logic [DATA_W-1:0]        sdram_readdata;
    logic                     sdram_readdatavalid;
    logic                     sdram_waitrequest;
    logic                     err_orphan;

    int n_pass  = 0;
    int n_total = 0;

    sdram_mport_arbiter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MAX_RD (MAX_RD)
    ) dut (
        .clk_clk             (clk_clk),
        .reset_reset_n       (reset_reset_n),
        .m_address           (m_address),
        .m_byteenable_n      (m_byteenable_n),
        .m_chipselect        (m_chipselect),
        .m_writedata         (m_writedata),
        .m_read_n            (m_read_n),
        .m_write_n           (m_write_n),
        .m_readdata          (m_readdata),
        .m_readdatavalid     (m_readdatavalid),
        .m_waitrequest       (m_waitrequest),
        .sdram_address       (sdram_address),
        .sdram_byteenable_n  (sdram_byteenable_n),
        .sdram_chipselect    (sdram_chipselect),
        .sdram_writedata     (sdram_writedata),
        .sdram_read_n        (sdram_read_n),
        .sdram_write_n       (sdram_write_n),
        .sdram_readdata      (sdram_readdata),
        .sdram_readdatavalid (sdram_readdatavalid),
        .sdram_waitrequest   (sdram_waitrequest),
        .err_orphan          (err_orphan)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_address           = '0;
        m_byteenable_n      = '0;
        m_chipselect        = '0;
        m_writedata         = '0;
        m_read_n            = '1;
        m_write_n           = '1;
        sdram_readdata      = '0;
        sdram_readdatavalid = 1'b0;
        sdram_waitrequest   = 1'b0;
    endtask

    task automatic set_cmd(input int ch, input logic is_wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be_n);
        m_chipselect[ch]                 = 1'b1;
        m_read_n[ch]                     = is_wr;
        m_write_n[ch]                    = !is_wr;
        m_address[ch*ADDR_W +: ADDR_W]   = a;
        m_writedata[ch*DATA_W +: DATA_W] = d;
        m_byteenable_n[ch*BE_W +: BE_W]  = be_n;
    endtask

    task automatic clr_cmd(input int ch);
        m_chipselect[ch] = 1'b0;
        m_read_n[ch]     = 1'b1;
        m_write_n[ch]    = 1'b1;
    endtask

    task automatic do_reset();
        reset_reset_n = 1'b0;
        clear_inputs();
        tick();
        reset_reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_wr;
        int exp_g [5];
`ifdef ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0, 0};
`else
        exp_g = '{0, 1, 2, 3, 0};
`endif
        reset_reset_n = 1'b0;
        clear_inputs();
        repeat (2) tick();
        #1;
        // ---------------- reset state
        check("rst_cmd", {sdram_chipselect, sdram_read_n, sdram_write_n, sdram_byteenable_n,
                          sdram_address, sdram_writedata}, {3'b011, 2'b00, 25'h0, 16'h0});
        check("rst_waitreq", m_waitrequest, 4'hF);
        check("rst_rdv", m_readdatavalid, 4'h0);
        check("rst_orphan", err_orphan, 1'b0);
        reset_reset_n = 1'b1;

        // ---------------- 1: ch2 write held by slave waitrequest for 3 cycles
        tick();
        set_cmd(2, 1'b1, 25'h0001234, 16'hBEEF, 2'b10);
        sdram_waitrequest = 1'b1;
        #1;
        check("t1_idle_wr", m_waitrequest, 4'hF);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("t1_hold", {sdram_chipselect, sdram_write_n, sdram_read_n, sdram_byteenable_n,
                              sdram_address, sdram_writedata}, {3'b101, 2'b10, 25'h0001234, 16'hBEEF});
            check("t1_stall", m_waitrequest, 4'hF);
        end
        tick();
        sdram_waitrequest = 1'b0;
        #1;
        check("t1_hold4", {sdram_chipselect, sdram_write_n, sdram_read_n, sdram_byteenable_n,
                           sdram_address, sdram_writedata}, {3'b101, 2'b10, 25'h0001234, 16'hBEEF});
        check("t1_accept", m_waitrequest, 4'b1011);
        tick();
        clr_cmd(2);
        #1;
        check("t1_deassert", {sdram_chipselect, sdram_read_n, sdram_write_n}, 3'b011);
        check("t1_after", m_waitrequest, 4'hF);
        tick(); #1;
        check("t1_idle", sdram_chipselect, 1'b0);

        // ---------------- 2: all channels reading continuously
        do_reset();
        for (int c = 0; c < NUM_CH; c++) set_cmd(c, 1'b0, 25'h100 + 25'(c), 16'h0, 2'b00);
        #1;
        check("t2_first_idle", m_waitrequest, 4'hF);
        for (int k = 0; k < 5; k++) begin
            tick(); #1;
            exp_wr = ~(4'b0001 << exp_g[k]);
            check("t2_grant", m_waitrequest, exp_wr);
            check("t2_addr", {sdram_read_n, sdram_address}, {1'b0, 25'h100 + 25'(exp_g[k])});
            tick(); #1;
            check("t2_bubble", m_waitrequest, 4'hF);
        end

        // ---------------- 3: ch1 then ch3 reads, in-order return
        do_reset();
        set_cmd(1, 1'b0, 25'h11, 16'h0, 2'b00);
        set_cmd(3, 1'b0, 25'h33, 16'h0, 2'b00);
        #1;
        tick(); #1;
        check("t3_g1", m_waitrequest, 4'b1101);
        check("t3_a1", sdram_address, 25'h11);
        tick();
        clr_cmd(1);
        #1;
        check("t3_bubble", m_waitrequest, 4'hF);
        tick(); #1;
        check("t3_g3", m_waitrequest, 4'b0111);
        check("t3_a3", sdram_address, 25'h33);
        tick();
        clr_cmd(3);
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = 16'hAAAA;
        #1;
        check("t3_rdv1", m_readdatavalid, 4'b0010);
        check("t3_data1", m_readdata, 16'hAAAA);
        tick();
        sdram_readdata = 16'h5555;
        #1;
        check("t3_rdv3", m_readdatavalid, 4'b1000);
        check("t3_data3", m_readdata, 16'h5555);
        tick();
        sdram_readdatavalid = 1'b0;
        #1;
        check("t3_rdv_none", m_readdatavalid, 4'b0000);
        check("t3_orphan", err_orphan, 1'b0);

        // ---------------- 4: MAX_RD outstanding reads block reads, not writes
        do_reset();
        set_cmd(0, 1'b0, 25'h200, 16'h0, 2'b00);
        #1;
        for (int i = 0; i < MAX_RD; i++) begin
            tick(); #1;
            check("t4_rd", m_waitrequest, 4'b1110);
            tick();
        end
        set_cmd(1, 1'b1, 25'h44, 16'h1234, 2'b00);
        #1;
        check("t4_full_idle", m_waitrequest, 4'hF);
        tick(); #1;
        check("t4_wr_grant", m_waitrequest, 4'b1101);
        check("t4_wr_cmd", {sdram_chipselect, sdram_write_n, sdram_read_n, sdram_address, sdram_writedata},
              {3'b101, 25'h44, 16'h1234});
        tick();
        clr_cmd(1);
        #1;
        check("t4_bubble", m_waitrequest, 4'hF);
        tick();
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = 16'h0C0C;
        #1;
        check("t4_rd_stalled", sdram_chipselect, 1'b0);
        check("t4_ret", m_readdatavalid, 4'b0001);
        tick();
        sdram_readdatavalid = 1'b0;
        #1;
        check("t4_pop_no_free", sdram_chipselect, 1'b0);
        tick(); #1;
        check("t4_rd_again", m_waitrequest, 4'b1110);
        tick();
        clr_cmd(0);
        #1;

        // ---------------- 5: read accept and readdatavalid in the same cycle
        do_reset();
        set_cmd(1, 1'b0, 25'h51, 16'h0, 2'b00);
        #1;
        tick(); #1;
        check("t5_g1", m_waitrequest, 4'b1101);
        tick();
        clr_cmd(1);
        set_cmd(2, 1'b0, 25'h52, 16'h0, 2'b00);
        #1;
        tick();
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = 16'h0F0F;
        #1;
        check("t5_g2", m_waitrequest, 4'b1011);
        check("t5_rdv_same", m_readdatavalid, 4'b0010);
        tick();
        clr_cmd(2);
        sdram_readdata = 16'hF0F0;
        #1;
        check("t5_rdv_next", m_readdatavalid, 4'b0100);
        check("t5_data", m_readdata, 16'hF0F0);
        tick();
        sdram_readdatavalid = 1'b0;
        #1;
        check("t5_orphan", err_orphan, 1'b0);
        // Both strobes low, or strobe without chipselect: not a request.
        m_chipselect[0] = 1'b1;
        m_read_n[0]     = 1'b0;
        m_write_n[0]    = 1'b0;
        m_read_n[3]     = 1'b0;
        tick(); #1;
        check("t5_noreq1", sdram_chipselect, 1'b0);
        tick(); #1;
        check("t5_noreq2", {sdram_chipselect, m_waitrequest}, {1'b0, 4'hF});

        // ---------------- 6: reset with reads outstanding -> orphan data
        do_reset();
        set_cmd(3, 1'b0, 25'h63, 16'h0, 2'b00);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check("t6_rd", m_waitrequest, 4'b0111);
            tick();
        end
        clr_cmd(3);
        #1;
        do_reset();
        sdram_readdatavalid = 1'b1;
        sdram_readdata      = 16'h1111;
        #1;
        check("t6_no_rdv", m_readdatavalid, 4'b0000);
        check("t6_orphan_pre", err_orphan, 1'b0);
        tick();
        sdram_readdatavalid = 1'b0;
        #1;
        check("t6_orphan_set", err_orphan, 1'b1);
        repeat (3) tick();
        #1;
        check("t6_orphan_sticky", err_orphan, 1'b1);
        do_reset();
        #1;
        check("t6_orphan_clr", err_orphan, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
